// File: rtl/decoder_pulse_scan.sv
// Registered one-hot decoder with a valid/ready request port and a per-line dwell counter.
// Single mode pulses one line; scan mode walks from the requested line up to the top line.
module decoder_pulse_scan #(
  parameter int ADDR_W    = 6,
  parameter int PULSE_LEN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [ADDR_W-1:0]      addr,
  output logic [(2**ADDR_W)-1:0] y,
  output logic [ADDR_W-1:0]      cur_addr,
  output logic                   busy,
  output logic                   done
);

  localparam int OUT_W = 2**ADDR_W;
  localparam logic [7:0]        RELOAD   = 8'(PULSE_LEN - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);
  localparam logic [OUT_W-1:0]  LSB_LINE = OUT_W'(1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state_r, state_s;
  logic                mode_r, mode_s;
  logic [7:0]          cnt_r, cnt_s;
  logic [ADDR_W-1:0]   cur_addr_r, cur_addr_s;
  logic [OUT_W-1:0]    y_r, y_s;
  logic                done_r, done_s;
  logic                accept_s;
  logic                last_line_s;

  function automatic logic [OUT_W-1:0] onehot(input logic [ADDR_W-1:0] a);
    return LSB_LINE << a;
  endfunction

  assign in_ready    = (state_r == IDLE) & en;
  assign accept_s    = in_valid & in_ready;
  assign last_line_s = (mode_r == 1'b0) | (cur_addr_r == TOP_ADDR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ACTIVE;
        else          state_s = IDLE;
      end
      ACTIVE: begin
        if (!en)                    state_s = IDLE;
        else if (cnt_r != 8'd0)     state_s = ACTIVE;
        else if (!last_line_s)      state_s = ACTIVE;
        else                        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs.
  always_comb begin
    mode_s     = mode_r;
    cnt_s      = cnt_r;
    cur_addr_s = cur_addr_r;
    y_s        = y_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cur_addr_s = addr;
          mode_s     = mode;
          cnt_s      = RELOAD;
          y_s        = onehot(addr);
        end else begin
          y_s        = {OUT_W{1'b0}};
        end
      end
      ACTIVE: begin
        if (!en) begin
          // Abort: drop the line without signalling completion.
          y_s   = {OUT_W{1'b0}};
          cnt_s = 8'd0;
        end else if (cnt_r != 8'd0) begin
          cnt_s = cnt_r - 8'd1;
        end else if (!last_line_s) begin
          cur_addr_s = cur_addr_r + ONE_ADDR;
          cnt_s      = RELOAD;
          y_s        = onehot(cur_addr_r + ONE_ADDR);
        end else begin
          y_s    = {OUT_W{1'b0}};
          done_s = 1'b1;
        end
      end
      default: begin
        y_s   = {OUT_W{1'b0}};
        cnt_s = 8'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= 1'b0;
      cnt_r      <= 8'd0;
      cur_addr_r <= {ADDR_W{1'b0}};
      y_r        <= {OUT_W{1'b0}};
      done_r     <= 1'b0;
    end else begin
      mode_r     <= mode_s;
      cnt_r      <= cnt_s;
      cur_addr_r <= cur_addr_s;
      y_r        <= y_s;
      done_r     <= done_s;
    end
  end

  assign y        = y_r;
  assign cur_addr = cur_addr_r;
  assign busy     = (state_r == ACTIVE);
  assign done     = done_r;

endmodule

// File: tb/tb_decoder_pulse_scan.sv
// Directed bench for decoder_pulse_scan: four instances cover the parameter sets the scenarios need.
module tb_decoder_pulse_scan;

  logic clk = 1'b0;
  logic rst_n, en;
  int   errors = 0;
  int   checks = 0;

  // a: ADDR_W=6 PULSE_LEN=1
  logic va, ma, ra, ba, da;
  logic [5:0]  aa, ca;
  logic [63:0] ya;
  // b: ADDR_W=3 PULSE_LEN=2
  logic vb, mb, rb, bb, db;
  logic [2:0] ab, cb;
  logic [7:0] yb;
  // c: ADDR_W=3 PULSE_LEN=3
  logic vc, mc, rc, bc, dc;
  logic [2:0] ac, cc;
  logic [7:0] yc;
  // d: ADDR_W=3 PULSE_LEN=1
  logic vd, md, rd, bd, dd;
  logic [2:0] ad, cd;
  logic [7:0] yd;

  always #5 clk = ~clk;

  decoder_pulse_scan #(.ADDR_W(6), .PULSE_LEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(va), .in_ready(ra), .mode(ma),
    .addr(aa), .y(ya), .cur_addr(ca), .busy(ba), .done(da));
  decoder_pulse_scan #(.ADDR_W(3), .PULSE_LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(vb), .in_ready(rb), .mode(mb),
    .addr(ab), .y(yb), .cur_addr(cb), .busy(bb), .done(db));
  decoder_pulse_scan #(.ADDR_W(3), .PULSE_LEN(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(vc), .in_ready(rc), .mode(mc),
    .addr(ac), .y(yc), .cur_addr(cc), .busy(bc), .done(dc));
  decoder_pulse_scan #(.ADDR_W(3), .PULSE_LEN(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(vd), .in_ready(rd), .mode(md),
    .addr(ad), .y(yd), .cur_addr(cd), .busy(bd), .done(dd));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    va = 1'b0; ma = 1'b0; aa = 6'd0;
    vb = 1'b0; mb = 1'b0; ab = 3'd0;
    vc = 1'b0; mc = 1'b0; ac = 3'd0;
    vd = 1'b0; md = 1'b0; ad = 3'd0;
    step(); step();
    checks++; if (ya !== 64'd0) begin errors++; $display("FAIL reset_y: got %h expected 0", ya); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ba); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", da); end
    checks++; if (ca !== 6'd0) begin errors++; $display("FAIL reset_cur_addr: got %0d expected 0", ca); end
    rst_n = 1'b1;
    step();
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ra); end
  endtask

  task automatic test_single();
    va = 1'b1; aa = 6'd37; ma = 1'b0;
    step();
    va = 1'b0;
    checks++; if (ya !== 64'h0000_0020_0000_0000) begin errors++; $display("FAIL single_y: got %h expected 0000002000000000", ya); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", ba); end
    checks++; if (ca !== 6'd37) begin errors++; $display("FAIL single_cur_addr: got %0d expected 37", ca); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL single_ready_busy: got %b expected 0", ra); end
    step();
    checks++; if (ya !== 64'd0) begin errors++; $display("FAIL single_y_end: got %h expected 0", ya); end
    checks++; if (da !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", da); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", ba); end
    step();
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL single_done_once: got %b expected 0", da); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_y [6];
    logic [2:0] exp_c [6];
    exp_y = '{8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80};
    exp_c = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
    vb = 1'b1; ab = 3'd5; mb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vb = 1'b0;
      checks++; if (yb !== exp_y[i]) begin errors++; $display("FAIL scan_y[%0d]: got %h expected %h", i, yb, exp_y[i]); end
      checks++; if (cb !== exp_c[i]) begin errors++; $display("FAIL scan_cur_addr[%0d]: got %0d expected %0d", i, cb, exp_c[i]); end
      checks++; if (bb !== 1'b1 || db !== 1'b0) begin errors++; $display("FAIL scan_busy_done[%0d]: got %b%b expected 10", i, bb, db); end
    end
    step();
    checks++; if (yb !== 8'h00) begin errors++; $display("FAIL scan_y_end: got %h expected 00", yb); end
    checks++; if (db !== 1'b1 || bb !== 1'b0) begin errors++; $display("FAIL scan_done: got busy=%b done=%b expected busy=0 done=1", bb, db); end
    checks++; if (cb !== 3'd7) begin errors++; $display("FAIL scan_cur_hold: got %0d expected 7", cb); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_y [8];
    exp_y = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h10, 8'h10, 8'h10, 8'h00};
    vc = 1'b1; ac = 3'd2; mc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) ac = 3'd4;
      if (i == 4) vc = 1'b0;
      checks++; if (yc !== exp_y[i]) begin errors++; $display("FAIL b2b_y[%0d]: got %h expected %h", i, yc, exp_y[i]); end
      if (i == 3 || i == 7) begin
        checks++; if (dc !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected 1", i, dc); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rc); end
      end
    end
    checks++; if (cc !== 3'd4) begin errors++; $display("FAIL b2b_cur_addr: got %0d expected 4", cc); end
  endtask

  task automatic test_en_abort();
    logic [7:0] exp_y [4];
    exp_y = '{8'h01, 8'h02, 8'h04, 8'h08};
    vd = 1'b1; ad = 3'd0; md = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vd = 1'b0;
      checks++; if (yd !== exp_y[i]) begin errors++; $display("FAIL abort_scan_y[%0d]: got %h expected %h", i, yd, exp_y[i]); end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (yd !== 8'h00 || bd !== 1'b0) begin errors++; $display("FAIL abort_idle[%0d]: got y=%h busy=%b expected y=00 busy=0", i, yd, bd); end
      checks++; if (dd !== 1'b0) begin errors++; $display("FAIL abort_no_done[%0d]: got %b expected 0", i, dd); end
      checks++; if (rd !== 1'b0) begin errors++; $display("FAIL abort_ready[%0d]: got %b expected 0", i, rd); end
    end
    checks++; if (cd !== 3'd3) begin errors++; $display("FAIL abort_cur_hold: got %0d expected 3", cd); end
    en = 1'b1;
    #1;
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL abort_ready_back: got %b expected 1", rd); end
  endtask

  task automatic test_async_reset();
    vd = 1'b1; ad = 3'd4; md = 1'b1;
    step();
    vd = 1'b0;
    step();
    step();
    checks++; if (yd !== 8'h40) begin errors++; $display("FAIL areset_pre_y: got %h expected 40", yd); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (yd !== 8'h00) begin errors++; $display("FAIL areset_y: got %h expected 00", yd); end
    checks++; if (cd !== 3'd0 || bd !== 1'b0) begin errors++; $display("FAIL areset_state: got cur=%0d busy=%b expected cur=0 busy=0", cd, bd); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (yd !== 8'h00 || dd !== 1'b0) begin errors++; $display("FAIL areset_stale: got y=%h done=%b expected y=00 done=0", yd, dd); end
    vd = 1'b1; ad = 3'd2; md = 1'b0;
    step();
    vd = 1'b0;
    checks++; if (yd !== 8'h04 || cd !== 3'd2) begin errors++; $display("FAIL areset_new_y: got y=%h cur=%0d expected y=04 cur=2", yd, cd); end
    step();
    checks++; if (yd !== 8'h00 || dd !== 1'b1) begin errors++; $display("FAIL areset_new_done: got y=%h done=%b expected y=00 done=1", yd, dd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_back_to_back();
    test_en_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
